ula_bus_initiator: RTL and testbench

- Synchronous Z80-style bus master: the initiator end of the CPU bus the ULA responds to (n_mreq, n_iorq, n_rd, n_wr, address, data, n_wait).
- Converts a valid/ready request interface into T-state-accurate memory and I/O bus cycles.
- Honours n_wait and a per-half-T clock enable (phi_en), which models ULA contention / clock stretching.
- Used as a CPU stand-in for ULA netlist benches and FPGA bring-up.

---
 rtl/ula_bus_pkg.sv | 13 +
 rtl/ula_bus_strobe_dec.sv | 23 ++
 rtl/ula_bus_initiator.sv | 100 ++++++++++
 tb/tb_ula_bus_initiator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ula_bus_pkg.sv
// ula_bus_pkg: shared T-state, cycle-type and strobe encodings for the ULA bus initiator
package ula_bus_pkg;
  typedef enum logic [3:0] {IDLE, T1H, T1L, T2H, T2L, TWH, TWL, T3H, T3L} state_t;
  typedef enum logic [1:0] {MEM_RD = 2'b00, MEM_WR = 2'b01, IO_RD = 2'b10, IO_WR = 2'b11} cyc_t;
  typedef struct packed {
    logic n_mreq;
    logic n_iorq;
    logic n_rd;
    logic n_wr;
    logic d_oe;
  } strobe_t;
  localparam strobe_t STB_IDLE = 5'b11110;
endpackage

// File: rtl/ula_bus_strobe_dec.sv
// ula_bus_strobe_dec: maps (state, type) to {n_mreq, n_iorq, n_rd, n_wr, d_oe}; ports: state, typ in, stb out
module ula_bus_strobe_dec
  import ula_bus_pkg::*;
(
  input  state_t  state,
  input  cyc_t    typ,
  output strobe_t stb
);
  logic io, wr, win_mem, win_io, win_wr;
  assign io      = typ[1];
  assign wr      = typ[0];
  assign win_mem = state inside {T1L, T2H, T2L, TWH, TWL, T3H};
  assign win_io  = state inside {T2H, T2L, TWH, TWL, T3H};
  assign win_wr  = state inside {T2L, TWH, TWL, T3H};
  always_comb begin
    stb        = STB_IDLE;
    stb.n_mreq = ~(~io & win_mem);
    stb.n_iorq = ~(io & win_io);
    stb.n_rd   = ~(~wr & (io ? win_io : win_mem));
    stb.n_wr   = ~(wr & (io ? win_io : win_wr));
    stb.d_oe   = wr & (win_mem | state == T3L);
  end
endmodule

// File: rtl/ula_bus_initiator.sv
// ula_bus_initiator: Z80-style bus master turning valid/ready requests into T-state bus cycles; ports: req/rsp handshake, a/d buses, strobes, n_wait, phi_en, busy
module ula_bus_initiator
  import ula_bus_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          phi_en,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_io,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] a,
  output logic          a_oe,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  input  logic [DW-1:0] d_in,
  output logic          n_mreq,
  output logic          n_iorq,
  output logic          n_rd,
  output logic          n_wr,
  input  logic          n_wait,
  output logic          busy
);
  state_t state_q, state_d;
  cyc_t typ_q, typ_d;
  strobe_t stb_q, stb_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] wdata_q, wdata_d, d_out_q, d_out_d, rdata_q, rdata_d;
  logic a_oe_q, a_oe_d, rsp_q, rsp_d, acc;
  assign req_ready = phi_en & ~rst & (state_q == IDLE | state_q == T3L);
  assign acc       = req_valid & req_ready;
  always_comb begin
    state_d = state_q;
    if (phi_en) begin
      unique case (state_q)
        IDLE:    state_d = acc ? T1H : IDLE;
        T1H:     state_d = T1L;
        T1L:     state_d = T2H;
        T2L:     state_d = ((typ_q[1] && IO_AUTO_WAIT != 0) || !n_wait) ? TWH : T3H;
        T2H:     state_d = T2L;
        TWH:     state_d = TWL;
        TWL:     state_d = !n_wait ? TWH : T3H;
        T3H:     state_d = T3L;
        T3L:     state_d = acc ? T1H : IDLE;
        default: state_d = IDLE;
      endcase
    end
    typ_d   = acc ? cyc_t'({req_io, req_write}) : typ_q;
    wdata_d = acc ? req_wdata : wdata_q;
    a_d     = acc ? req_addr : a_q;
    a_oe_d  = state_d != IDLE;
    d_out_d = (phi_en && state_d == T1L) ? (typ_d[0] ? wdata_d : '0) : d_out_q;
    rsp_d   = phi_en && state_q == T3H;
    rdata_d = rsp_d ? (typ_q[0] ? '0 : d_in) : rdata_q;
  end
  // Strobes are decoded from the next state so the registered outputs track the current state.
  ula_bus_strobe_dec u_dec (.state(state_d), .typ(typ_d), .stb(stb_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      typ_q   <= MEM_RD;
      stb_q   <= STB_IDLE;
      a_q     <= '0;
      a_oe_q  <= 1'b0;
      wdata_q <= '0;
      d_out_q <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      stb_q   <= stb_d;
      a_q     <= a_d;
      a_oe_q  <= a_oe_d;
      wdata_q <= wdata_d;
      d_out_q <= d_out_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
  end
  assign a         = a_q;
  assign a_oe      = a_oe_q;
  assign d_out     = d_out_q;
  assign d_oe      = stb_q.d_oe;
  assign n_mreq    = stb_q.n_mreq;
  assign n_iorq    = stb_q.n_iorq;
  assign n_rd      = stb_q.n_rd;
  assign n_wr      = stb_q.n_wr;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_ula_bus_initiator.sv
// tb_ula_bus_initiator: randomized self-checking bench against a timing-arithmetic model of the bus cycles
module tb_ula_bus_initiator;
  logic clk = 0, rst, phi_en, req_valid, req_ready, req_write, req_io;
  logic [15:0] req_addr, a;
  logic [7:0] req_wdata, rsp_rdata, d_out, d_in;
  logic rsp_valid, a_oe, d_oe, n_mreq, n_iorq, n_rd, n_wr, n_wait, busy;
  int checks = 0, errors = 0;

  ula_bus_initiator dut (
    .clk(clk), .rst(rst), .phi_en(phi_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .a(a), .a_oe(a_oe), .d_out(d_out),
    .d_oe(d_oe), .d_in(d_in), .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr),
    .n_wait(n_wait), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1; phi_en = 1; req_valid = 0; req_write = 0; req_io = 0;
    req_addr = 0; req_wdata = 0; d_in = 0; n_wait = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({n_mreq, n_iorq, n_rd, n_wr, a_oe, d_oe, rsp_valid, busy, req_ready} !== 9'b111100000
        || a !== 0 || d_out !== 0 || rsp_rdata !== 0) begin
      errors++;
      $display("FAIL reset: strobes=%b a=%h a_oe=%b d_out=%h d_oe=%b rsp=%b rdata=%h busy=%b ready=%b, required 1111/0/0/0/0/0/0/0/0",
               {n_mreq, n_iorq, n_rd, n_wr}, a, a_oe, d_out, d_oe, rsp_valid, rsp_rdata, busy, req_ready);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_ignore();
    req_valid = 1; phi_en = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 0 || req_ready !== 0) begin
        errors++;
        $display("FAIL ignore_stalled: busy=%b ready=%b, required 0/0", busy, req_ready);
      end
    end
    req_valid = 0; phi_en = 1;
    @(negedge clk);
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL ignore_novalid: busy=%b, required 0", busy);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    checks++;
    if ({busy, a_oe, d_oe, rsp_valid} !== 4'b0 || {n_mreq, n_iorq, n_rd, n_wr} !== 4'hF) begin
      errors++;
      $display("FAIL idle: busy=%b a_oe=%b d_oe=%b rsp=%b strobes=%b, required 0/0/0/0/1111",
               busy, a_oe, d_oe, rsp_valid, {n_mreq, n_iorq, n_rd, n_wr});
    end
  endtask

  // One bus cycle with w extra wait pairs and an s-clk stall while in T2L (half-T index 4).
  // Called at a negedge with the initiator idle or in T3L; returns at the negedge showing rsp_valid.
  task automatic txn(input bit io, input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                     input logic [7:0] rd, input int w, input int s);
    int wt, first, idx, stalled, clk_n, rsp_clk;
    int c_mreq, c_iorq, c_rd, c_wr, c_doe, f_main, f_wr;
    bit done, bad_bus, bad_frz, bad_dout;
    logic [30:0] snap, prev;
    logic [7:0] exp_rd;
    wt = w + (io ? 1 : 0);
    first = io ? 6 : 4;
    idx = 0; stalled = 0; clk_n = 0; rsp_clk = -1;
    c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_doe = 0; f_main = -1; f_wr = -1;
    done = 0; bad_bus = 0; bad_frz = 0; bad_dout = 0; prev = '0;
    req_valid = 1; req_io = io; req_write = wr; req_addr = addr; req_wdata = wd;
    phi_en = 1; n_wait = 1; d_in = ~rd;
    checks++;
    if (req_ready !== 1) begin
      errors++;
      $display("FAIL ready: req_ready=%b, required 1", req_ready);
    end
    @(posedge clk);
    while (!done && clk_n < 300) begin
      @(negedge clk);
      clk_n++;
      if (phi_en) idx++; else stalled++;
      req_valid = 0;
      snap = {a, a_oe, d_out, d_oe, n_mreq, n_iorq, n_rd, n_wr, busy};
      if (!phi_en && snap !== prev) bad_frz = 1;
      if (a !== addr || a_oe !== 1 || busy !== 1) bad_bus = 1;
      if (d_oe === 1 && d_out !== wd) bad_dout = 1;
      if (!n_mreq) c_mreq++;
      if (!n_iorq) c_iorq++;
      if (!n_rd) c_rd++;
      if (!n_wr) c_wr++;
      if (d_oe) c_doe++;
      if (f_main < 0 && !(io ? n_iorq : n_mreq)) f_main = clk_n;
      if (f_wr < 0 && !n_wr) f_wr = clk_n;
      if (rsp_valid) begin done = 1; rsp_clk = clk_n; end
      prev = snap;
      if (!done) begin
        phi_en = !(idx == 4 && stalled < s);
        n_wait = idx >= first + 2 * w;
        d_in = (idx == 5 + 2 * wt) ? rd : ~rd;
      end
    end
    phi_en = 1; n_wait = 1;
    exp_rd = wr ? 8'h00 : rd;
    checks += 4;
    if (bad_bus) begin errors++; $display("FAIL bus_hold: a/a_oe/busy dropped during cycle to %h", addr); end
    if (bad_frz) begin errors++; $display("FAIL freeze: outputs changed while phi_en=0 (s=%0d)", s); end
    if (bad_dout) begin errors++; $display("FAIL d_out: d_out differs from %h while d_oe=1", wd); end
    if (rsp_clk !== 6 + 2 * wt + s) begin
      errors++;
      $display("FAIL rsp_time: rsp at clk %0d, required %0d (io=%0d wr=%0d w=%0d s=%0d)", rsp_clk, 6 + 2 * wt + s, io, wr, w, s);
    end
    checks += 3;
    if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL rdata: got %h, required %h", rsp_rdata, exp_rd); end
    if (c_doe !== (wr ? 5 + 2 * wt + s : 0)) begin
      errors++; $display("FAIL d_oe_len: got %0d clks, required %0d", c_doe, wr ? 5 + 2 * wt + s : 0);
    end
    if (f_main !== (io ? 3 : 2)) begin
      errors++; $display("FAIL first_strobe: got clk %0d, required %0d", f_main, io ? 3 : 2);
    end
    checks += 4;
    if (c_mreq !== (io ? 0 : 4 + 2 * wt + s)) begin
      errors++; $display("FAIL mreq_len: got %0d, required %0d", c_mreq, io ? 0 : 4 + 2 * wt + s);
    end
    if (c_iorq !== (io ? 3 + 2 * wt + s : 0)) begin
      errors++; $display("FAIL iorq_len: got %0d, required %0d", c_iorq, io ? 3 + 2 * wt + s : 0);
    end
    if (c_rd !== (wr ? 0 : (io ? 3 : 4) + 2 * wt + s)) begin
      errors++; $display("FAIL rd_len: got %0d, required %0d", c_rd, wr ? 0 : (io ? 3 : 4) + 2 * wt + s);
    end
    if (c_wr !== (!wr ? 0 : (io ? 3 : 2) + 2 * wt + s)) begin
      errors++; $display("FAIL wr_len: got %0d, required %0d", c_wr, !wr ? 0 : (io ? 3 : 2) + 2 * wt + s);
    end
    if (wr) begin
      checks++;
      if (f_wr !== (io ? 3 : 4)) begin
        errors++; $display("FAIL first_wr: got clk %0d, required %0d", f_wr, io ? 3 : 4);
      end
    end
  endtask

  task automatic test_directed();
    txn(0, 0, 16'h4000, 8'h00, 8'hA5, 0, 0); idle_check();
    txn(0, 1, 16'h5800, 8'h3C, 8'h77, 0, 0); idle_check();
    txn(1, 0, 16'h00FE, 8'h00, 8'h1F, 0, 0); idle_check();
    txn(0, 0, 16'h1234, 8'h00, 8'h5A, 0, 5); idle_check();
    txn(0, 0, 16'h8001, 8'h00, 8'hC3, 2, 0); idle_check();
    txn(1, 1, 16'hBFFD, 8'h81, 8'h00, 1, 2); idle_check();
  endtask

  task automatic test_back_to_back();
    txn(0, 1, 16'h4001, 8'h11, 8'h00, 0, 0);
    txn(0, 0, 16'h4002, 8'h00, 8'h22, 0, 0);
    txn(1, 0, 16'h00FE, 8'h00, 8'h33, 1, 0);
    idle_check();
  endtask

  task automatic test_random();
    bit b2b;
    for (int i = 0; i < 30; i++) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
          8'($urandom), $urandom_range(0, 2), $urandom_range(0, 1) ? $urandom_range(1, 4) : 0);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) idle_check();
    end
    idle_check();
  endtask

  task automatic test_reset_abort();
    bit seen;
    req_valid = 1; req_io = 1; req_write = 0; req_addr = 16'h7FFE; req_wdata = 0;
    phi_en = 1; n_wait = 1; d_in = 8'h99;
    @(posedge clk);
    repeat (5) begin @(negedge clk); req_valid = 0; end
    checks++;
    if (n_iorq !== 0 || busy !== 1) begin
      errors++; $display("FAIL abort_setup: n_iorq=%b busy=%b, required 0/1", n_iorq, busy);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({n_mreq, n_iorq, n_rd, n_wr, a_oe, d_oe, rsp_valid, busy, req_ready} !== 9'b111100000
        || a !== 0 || d_out !== 0 || rsp_rdata !== 0) begin
      errors++;
      $display("FAIL abort_reset: strobes=%b a=%h a_oe=%b d_oe=%b rsp=%b busy=%b ready=%b, required 1111/0/0/0/0/0/0",
               {n_mreq, n_iorq, n_rd, n_wr}, a, a_oe, d_oe, rsp_valid, busy, req_ready);
    end
    rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_rsp: rsp_valid or busy seen after reset, required none"); end
    txn(0, 0, 16'h6000, 8'h00, 8'h4E, 0, 0);
    idle_check();
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
